// File: rtl/wb_periph_arbiter_if.sv
// wb_periph_arbiter_if: signal bundle for the two-master peripheral arbiter.
// Port summary: masters m0/m1 (stb/we/adr/dat in, ack/dat out),
// slave side (stb/we/adr/dat out, ack/dat in), grant/timeout-error status.
// The slave modport is the arbiter's own view; master is the surrounding
// environment (masters, peripheral and status logic).
interface wb_periph_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  m0_stb_i;
  logic                  m0_we_i;
  logic [DATA_WIDTH-1:0] m0_adr_i;
  logic [DATA_WIDTH-1:0] m0_dat_i;
  logic                  m0_ack_o;
  logic [DATA_WIDTH-1:0] m0_dat_o;

  logic                  m1_stb_i;
  logic                  m1_we_i;
  logic [DATA_WIDTH-1:0] m1_adr_i;
  logic [DATA_WIDTH-1:0] m1_dat_i;
  logic                  m1_ack_o;
  logic [DATA_WIDTH-1:0] m1_dat_o;

  logic                  s_stb_o;
  logic                  s_we_o;
  logic [DATA_WIDTH-1:0] s_adr_o;
  logic [DATA_WIDTH-1:0] s_dat_o;
  logic                  s_ack_i;
  logic [DATA_WIDTH-1:0] s_dat_i;

  logic [1:0]            grant_o;
  logic                  timeout_err_o;
  logic                  err_clr_i;

  modport slave (
    input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_ack_o, m0_dat_o,
    input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_ack_o, m1_dat_o,
    output s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i,
    output grant_o, timeout_err_o,
    input  err_clr_i
  );

  modport master (
    output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_ack_o, m0_dat_o,
    output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_ack_o, m1_dat_o,
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i,
    input  grant_o, timeout_err_o,
    output err_clr_i
  );
endinterface

// File: rtl/wb_periph_arbiter.sv
// wb_periph_arbiter: round-robin arbiter, core (m0) and debug (m1) masters
// onto one peripheral bus, with slave-ack timeout. Ports: clk, reset, bus.
module wb_periph_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  wb_periph_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic [1:0]            grant_q, grant_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] sdat_q, sdat_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] dat0_q, dat0_d;
  logic [DATA_WIDTH-1:0] dat1_q, dat1_d;
  logic                  err_q, err_d;

  logic                  pick1;
  logic                  finish;
  logic                  tmo;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sdat_d  = sdat_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
    err_d   = err_q;
    pick1   = 1'b0;
    finish  = 1'b0;
    tmo     = 1'b0;
    rdata   = bus.s_dat_i;

    unique case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        // on a tie, serve whoever was not served last
        pick1 = bus.m1_stb_i &
                (~bus.m0_stb_i | ~last_q);
        if (bus.m0_stb_i | bus.m1_stb_i) begin
          state_d = BUSY;
          cnt_d   = '0;
          last_d  = pick1;
          grant_d = pick1 ? 2'b10 : 2'b01;
          stb_d   = 1'b1;
          we_d    = pick1 ? bus.m1_we_i
                          : bus.m0_we_i;
          adr_d   = pick1 ? bus.m1_adr_i
                          : bus.m0_adr_i;
          sdat_d  = pick1 ? bus.m1_dat_i
                          : bus.m0_dat_i;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // an ack on the last allowed cycle still wins
        if (bus.s_ack_i) begin
          finish = 1'b1;
        end else if (cnt_d == TMO) begin
          finish = 1'b1;
          tmo    = 1'b1;
          rdata  = '1;
        end
        if (finish) begin
          state_d = DONE;
          stb_d   = 1'b0;
          if (grant_q[1]) begin
            ack1_d = 1'b1;
            dat1_d = rdata;
          end else begin
            ack0_d = 1'b1;
            dat0_d = rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase

    // a fresh timeout beats a clear on the same edge
    if (tmo) begin
      err_d = 1'b1;
    end else if (bus.err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sdat_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      dat0_q  <= '0;
      dat1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sdat_q  <= sdat_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_stb_o       = stb_q;
  assign bus.s_we_o        = we_q;
  assign bus.s_adr_o       = adr_q;
  assign bus.s_dat_o       = sdat_q;
  assign bus.m0_ack_o      = ack0_q;
  assign bus.m1_ack_o      = ack1_q;
  assign bus.m0_dat_o      = dat0_q;
  assign bus.m1_dat_o      = dat1_q;
  assign bus.grant_o       = grant_q;
  assign bus.timeout_err_o = err_q;

endmodule

// File: tb/tb_wb_periph_arbiter.sv
// tb_wb_periph_arbiter: directed and randomized bench for the arbiter,
// checked every cycle against a transaction-level model.
module tb_wb_periph_arbiter;

  localparam int DW  = 8;
  localparam int TMO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_periph_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  wb_periph_arbiter #(
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  bit rnd_on = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, want, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // ph: 0 idle, 1 slave request in flight, 2 completion cycle
  int            ph      = 0;
  int            own     = 0;
  int            last    = 1;
  int            t_grant = 0;
  int            edge_n  = 0;
  int            nxt;
  logic          tmo_now;
  logic          e_we    = 0;
  logic [DW-1:0] e_adr   = 0;
  logic [DW-1:0] e_sdat  = 0;
  logic [DW-1:0] e_dat [2] = '{0, 0};
  logic          e_err   = 0;

  always_comb begin
    nxt = 0;
    if (bus.m0_stb_i && bus.m1_stb_i) nxt = 1 - last;
    else if (bus.m1_stb_i) nxt = 1;
  end

  // timeout: TMO edges after the grant edge with no ack seen
  always_comb
    tmo_now = (ph == 1) && !bus.s_ack_i &&
              (edge_n - t_grant == TMO);

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (reset) begin
      ph       <= 0;
      own      <= 0;
      last     <= 1;
      e_we     <= 0;
      e_adr    <= 0;
      e_sdat   <= 0;
      e_dat[0] <= 0;
      e_dat[1] <= 0;
      e_err    <= 0;
    end else begin
      if (ph == 0 && (bus.m0_stb_i || bus.m1_stb_i)) begin
        ph      <= 1;
        own     <= nxt;
        last    <= nxt;
        t_grant <= edge_n;
        e_we    <= nxt ? bus.m1_we_i  : bus.m0_we_i;
        e_adr   <= nxt ? bus.m1_adr_i : bus.m0_adr_i;
        e_sdat  <= nxt ? bus.m1_dat_i : bus.m0_dat_i;
      end else if (ph == 1 && bus.s_ack_i) begin
        ph         <= 2;
        e_dat[own] <= bus.s_dat_i;
      end else if (tmo_now) begin
        ph         <= 2;
        e_dat[own] <= '1;
      end else if (ph == 2) begin
        ph <= 0;
      end
      if (tmo_now) e_err <= 1;
      else if (bus.err_clr_i) e_err <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", bus.grant_o,
          ph == 0 ? 0 : (own == 1 ? 2 : 1));
      chk("s_stb", bus.s_stb_o, ph == 1);
      if (ph == 1) begin
        chk("s_we", bus.s_we_o, e_we);
        chk("s_adr", bus.s_adr_o, e_adr);
        chk("s_dat", bus.s_dat_o, e_sdat);
      end
      chk("m0_ack", bus.m0_ack_o, ph == 2 && own == 0);
      chk("m1_ack", bus.m1_ack_o, ph == 2 && own == 1);
      chk("m0_dat", bus.m0_dat_o, e_dat[0]);
      chk("m1_dat", bus.m1_dat_o, e_dat[1]);
      chk("err", bus.timeout_err_o, e_err);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.m0_stb_i  = 0;
    bus.m0_we_i   = 0;
    bus.m0_adr_i  = 0;
    bus.m0_dat_i  = 0;
    bus.m1_stb_i  = 0;
    bus.m1_we_i   = 0;
    bus.m1_adr_i  = 0;
    bus.m1_dat_i  = 0;
    bus.s_ack_i   = 0;
    bus.s_dat_i   = 0;
    bus.err_clr_i = 0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic wait_stb();
    int n = 0;
    tick();
    while (!bus.s_stb_o && n < 50) begin
      tick();
      n++;
    end
    chk("stb_seen", bus.s_stb_o, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_stb"}, bus.s_stb_o, 0);
    chk({tag, "_s_we"}, bus.s_we_o, 0);
    chk({tag, "_s_adr"}, bus.s_adr_o, 0);
    chk({tag, "_s_dat"}, bus.s_dat_o, 0);
    chk({tag, "_m0_ack"}, bus.m0_ack_o, 0);
    chk({tag, "_m1_ack"}, bus.m1_ack_o, 0);
    chk({tag, "_m0_dat"}, bus.m0_dat_o, 0);
    chk({tag, "_m1_dat"}, bus.m1_dat_o, 0);
    chk({tag, "_grant"}, bus.grant_o, 0);
    chk({tag, "_err"}, bus.timeout_err_o, 0);
  endtask

  // ---------------- random drivers ----------------
  logic          r_stb [2] = '{0, 0};
  logic          r_we  [2];
  logic [DW-1:0] r_adr [2];
  logic [DW-1:0] r_dat [2];

  initial begin : rnd_drv
    int  p_ack = 50;
    int  cyc = 0;
    logic a;
    forever begin
      @(negedge clk);
      if (rnd_on) begin
        if (cyc % 50 == 0) begin
          case ($urandom_range(3))
            0: p_ack = 0;
            1: p_ack = 15;
            2: p_ack = 50;
            default: p_ack = 100;
          endcase
        end
        cyc++;
        for (int m = 0; m < 2; m++) begin
          a = (m == 1) ? bus.m1_ack_o : bus.m0_ack_o;
          if (r_stb[m] && a) r_stb[m] = 0;
          else if (r_stb[m] && $urandom_range(99) < 1)
            r_stb[m] = 0;
          if (!r_stb[m] && $urandom_range(99) < 40) begin
            r_stb[m] = 1;
            r_we[m]  = 1'($urandom);
            r_adr[m] = DW'($urandom);
            r_dat[m] = DW'($urandom);
          end
        end
        bus.m0_stb_i  = r_stb[0];
        bus.m0_we_i   = r_we[0];
        bus.m0_adr_i  = r_adr[0];
        bus.m0_dat_i  = r_dat[0];
        bus.m1_stb_i  = r_stb[1];
        bus.m1_we_i   = r_we[1];
        bus.m1_adr_i  = r_adr[1];
        bus.m1_dat_i  = r_dat[1];
        bus.s_ack_i   = ($urandom_range(99) < p_ack);
        bus.s_dat_i   = DW'($urandom);
        bus.err_clr_i = ($urandom_range(99) < 5);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [DW-1:0] q_adr [$];
  logic [DW-1:0] q_sd  [$];
  int            q_ack [$];
  logic [1:0]    q_g   [$];
  logic [1:0]    exp_g [6] = '{2'b01, 2'b10, 2'b01,
                               2'b10, 2'b01, 2'b10};

  initial begin : main
    logic       prev;
    logic [1:0] pg;
    int         n;

    clr_in();
    @(negedge clk);
    do_reset();
    chk_en = 1;
    chk_zero("rst");

    // single read: 0x3A returns 0x5C
    bus.m0_stb_i = 1;
    bus.m0_adr_i = 8'h3A;
    wait_stb();
    chk("rd_adr", bus.s_adr_o, 8'h3A);
    chk("rd_we", bus.s_we_o, 0);
    chk("rd_grant", bus.grant_o, 2'b01);
    repeat (3) tick();
    bus.s_ack_i = 1;
    bus.s_dat_i = 8'h5C;
    tick();
    bus.s_ack_i  = 0;
    bus.m0_stb_i = 0;
    chk("rd_ack", bus.m0_ack_o, 1);
    chk("rd_dat", bus.m0_dat_o, 8'h5C);
    tick();
    chk("rd_ack_once", bus.m0_ack_o, 0);
    chk("rd_idle", bus.grant_o, 0);
    chk("rd_hold", bus.m0_dat_o, 8'h5C);

    // simultaneous writes after reset, immediate acks
    do_reset();
    bus.m0_stb_i = 1; bus.m0_we_i = 1;
    bus.m0_adr_i = 8'h20; bus.m0_dat_i = 8'h11;
    bus.m1_stb_i = 1; bus.m1_we_i = 1;
    bus.m1_adr_i = 8'h21; bus.m1_dat_i = 8'h22;
    bus.s_ack_i  = 1;
    prev = 0;
    for (int i = 0; i < 30; i++) begin
      if (!bus.m0_stb_i && !bus.m1_stb_i) break;
      tick();
      if (bus.s_stb_o && !prev) begin
        q_adr.push_back(bus.s_adr_o);
        q_sd.push_back(bus.s_dat_o);
      end
      prev = bus.s_stb_o;
      if (bus.m0_ack_o) begin
        q_ack.push_back(0);
        bus.m0_stb_i = 0;
      end
      if (bus.m1_ack_o) begin
        q_ack.push_back(1);
        bus.m1_stb_i = 0;
      end
    end
    bus.s_ack_i = 0;
    chk("wr_n_req", q_adr.size(), 2);
    chk("wr_n_ack", q_ack.size(), 2);
    if (q_adr.size() >= 2 && q_ack.size() >= 2) begin
      chk("wr_adr0", q_adr[0], 8'h20);
      chk("wr_adr1", q_adr[1], 8'h21);
      chk("wr_dat0", q_sd[0], 8'h11);
      chk("wr_dat1", q_sd[1], 8'h22);
      chk("wr_ack0", q_ack[0], 0);
      chk("wr_ack1", q_ack[1], 1);
    end
    tick();

    // fairness: continuous requests from both
    do_reset();
    bus.m0_stb_i = 1;
    bus.m1_stb_i = 1;
    bus.s_ack_i  = 1;
    pg = 0;
    for (int i = 0; i < 80; i++) begin
      if (q_g.size() >= 6) break;
      tick();
      if (bus.grant_o != 0 && pg == 0)
        q_g.push_back(bus.grant_o);
      pg = bus.grant_o;
    end
    chk("rr_count", q_g.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < q_g.size())
        chk($sformatf("rr_g%0d", k), q_g[k], exp_g[k]);
    clr_in();
    repeat (3) tick();

    // timeout on a debug read
    do_reset();
    bus.m1_stb_i = 1;
    bus.m1_adr_i = 8'h40;
    wait_stb();
    n = 0;
    while (!bus.m1_ack_o && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_dat", bus.m1_dat_o, 8'hFF);
    chk("to_err", bus.timeout_err_o, 1);
    chk("to_m0_ack", bus.m0_ack_o, 0);
    bus.m1_stb_i = 0;
    repeat (5) tick();
    chk("to_sticky", bus.timeout_err_o, 1);
    bus.err_clr_i = 1;
    tick();
    bus.err_clr_i = 0;
    chk("to_clr", bus.timeout_err_o, 0);

    // ack on the last allowed wait cycle wins
    bus.m0_stb_i = 1;
    bus.m0_adr_i = 8'h55;
    wait_stb();
    repeat (15) tick();
    bus.s_ack_i = 1;
    bus.s_dat_i = 8'h77;
    tick();
    bus.s_ack_i  = 0;
    bus.m0_stb_i = 0;
    chk("bd_ack", bus.m0_ack_o, 1);
    chk("bd_dat", bus.m0_dat_o, 8'h77);
    chk("bd_err", bus.timeout_err_o, 0);
    tick();

    // clear and timeout on the same edge
    bus.m1_stb_i = 1;
    bus.m1_adr_i = 8'h66;
    wait_stb();
    repeat (15) tick();
    bus.err_clr_i = 1;
    tick();
    bus.err_clr_i = 0;
    bus.m1_stb_i  = 0;
    chk("cl_ack", bus.m1_ack_o, 1);
    chk("cl_err", bus.timeout_err_o, 1);
    tick();
    chk("cl_err_hold", bus.timeout_err_o, 1);

    // reset two cycles into a transaction
    bus.m0_stb_i = 1;
    bus.m0_adr_i = 8'h12;
    wait_stb();
    tick();
    tick();
    reset = 1;
    bus.m0_stb_i = 0;
    tick();
    reset = 0;
    chk_zero("mid");
    repeat (3) begin
      tick();
      chk("mid_noack", bus.m0_ack_o | bus.m1_ack_o, 0);
    end
    bus.m0_stb_i = 1;
    bus.m0_we_i  = 1;
    bus.m0_adr_i = 8'h0A;
    bus.m0_dat_i = 8'h99;
    bus.s_ack_i  = 1;
    wait_stb();
    chk("post_adr", bus.s_adr_o, 8'h0A);
    chk("post_dat", bus.s_dat_o, 8'h99);
    chk("post_we", bus.s_we_o, 1);
    tick();
    bus.m0_stb_i = 0;
    bus.s_ack_i  = 0;
    chk("post_ack", bus.m0_ack_o, 1);
    tick();

    // randomized traffic
    rnd_on = 1;
    for (int c = 0; c < 4000; c++) begin
      if (n_bad > 100) break;
      tick();
    end
    rnd_on = 0;
    @(negedge clk);
    clr_in();
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
